instr_fetch_sequencer: RTL and testbench

Datapath-side partner of the multicycle control FSM. It owns the program counter, instruction memory and instruction register, and presents the current opcode to the FSM's 6-bit opcode input. It acts on the FSM's 4-bit state output: fetch, PC increment, BEQ branch and J jump. It also counts retired instructions and flags illegal opcodes or illegal states.

---
 rtl/mc_ctrl_pkg.sv | 35 +++
 rtl/instr_mem.sv | 24 ++
 rtl/instr_fetch_sequencer.sv | 102 ++++++++++
 tb/tb_instr_fetch_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM and its fetch datapath.
// Opcode constants, state encodings and small decode helpers.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_JUMP    = 4'd9
    } state_e;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

    // States whose successor is fetch, i.e. the last cycle of an instruction.
    function automatic logic is_retire_state(input logic [3:0] st);
        return (st == S_MEMWB) || (st == S_MEMWR) || (st == S_RTYPEWB) ||
               (st == S_BEQEX) || (st == S_JUMP);
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous write port, one combinational read port.
// No reset; the read returns the pre-edge word on a same-address write.
module instr_mem #(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_sequencer.sv
// PC, instruction register, retire counter and error flag driven by the
// control FSM state; presents IR[31:26] back to the FSM as the opcode.
module instr_fetch_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic              zero,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic [5:0]        opcode,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  instr_count,
    output logic              illegal
);

    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ill_q, ill_d;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] br_off;

    instr_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (rdata)
    );

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        // Sign-extended offset truncated to the PC width wraps naturally.
        br_off  = ADDR_W'({{16{instr_q[15]}}, instr_q[15:0]});
        case (state)
            S_FETCH: begin
                instr_d = rdata;
                pc_d    = pc_q + PC_ONE;
            end
            S_DECODE: begin
                if (!is_legal_opcode(instr_q[31:26])) begin
                    ill_d = 1'b1;
                end
            end
            S_BEQEX: begin
                if (zero) begin
                    pc_d = pc_q + br_off;
                end
            end
            S_JUMP: begin
                pc_d = instr_q[ADDR_W-1:0];
            end
            S_MEMADR, S_MEMRD, S_MEMWB,
            S_MEMWR, S_RTYPEEX, S_RTYPEWB: begin
                pc_d = pc_q;
            end
            default: begin
                ill_d = 1'b1;
            end
        endcase
        if (is_retire_state(state)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_count = cnt_q;
    assign illegal     = ill_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: constant vector table, corner sequences,
// and random traffic against an instruction-level reference model.
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  state = 4'd2;
    logic        zero = 1'b0;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [5:0]  opcode;
    logic [31:0] instr;
    logic [5:0]  pc;
    logic [15:0] instr_count;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_mem [64];
    int          m_pc = 0;
    logic [31:0] m_instr = '0;
    int          m_cnt = 0;
    bit          m_ill = 1'b0;

    instr_fetch_sequencer #(.ADDR_W(6), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .zero        (zero),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .opcode      (opcode),
        .instr       (instr),
        .pc          (pc),
        .instr_count (instr_count),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic        z;
        logic [5:0]  pc;
        logic [31:0] ins;
        logic [15:0] cnt;
        logic        ill;
    } vec_t;

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02};
    endfunction

    task automatic model_reset();
        m_pc = 0;
        m_instr = '0;
        m_cnt = 0;
        m_ill = 1'b0;
    endtask

    task automatic model_edge(input bit rst_n, input int st, input bit z,
                              input bit we, input int a, input logic [31:0] d);
        if (rst_n) begin
            if (st == 0) begin
                m_instr = m_mem[m_pc];
                m_pc = (m_pc + 1) % 64;
            end else if (st == 1) begin
                if (!legal_op(m_instr[31:26])) m_ill = 1'b1;
            end else if (st == 8) begin
                if (z) m_pc = (m_pc + int'($signed(m_instr[15:0]))) & 63;
            end else if (st == 9) begin
                m_pc = int'(m_instr[5:0]);
            end else if (st >= 10) begin
                m_ill = 1'b1;
            end
            if (st inside {4, 5, 7, 8, 9}) m_cnt = (m_cnt + 1) % 65536;
        end
        if (we) m_mem[a] = d;
    endtask

    task automatic check(input string nm, input logic [5:0] epc,
                         input logic [31:0] ei, input logic [15:0] ec,
                         input logic eil);
        n_vec++;
        if ({pc, instr, instr_count, illegal, opcode} !==
            {epc, ei, ec, eil, ei[31:26]}) begin
            n_err++;
            $display("FAIL %s: got pc=%0d instr=%h cnt=%0d ill=%b op=%h, want pc=%0d instr=%h cnt=%0d ill=%b op=%h",
                     nm, pc, instr, instr_count, illegal, opcode,
                     epc, ei, ec, eil, ei[31:26]);
        end
    endtask

    task automatic check_model(input string nm);
        check(nm, m_pc[5:0], m_instr, m_cnt[15:0], m_ill);
    endtask

    // Entered just after a rising edge; returns 1 time unit after the next one.
    task automatic step(input logic [3:0] st, input logic z, input logic we,
                        input logic [5:0] a, input logic [31:0] d);
        state = st;
        zero = z;
        prog_we = we;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        model_edge(reset, int'(st), z, we, int'(a), d);
        #1;
        check_model("model");
        prog_we = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        step(4'd2, 1'b0, 1'b1, a, d);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_async", 6'd0, 32'd0, 16'd0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 6'd0, 32'd0);
        reset = 1'b1;
    endtask

    vec_t vt[$];
    logic [5:0] ops [6];

    initial begin
        vt = '{
            '{4'd0, 1'b0, 6'd1,  32'h8C000000, 16'd0, 1'b0},
            '{4'd1, 1'b0, 6'd1,  32'h8C000000, 16'd0, 1'b0},
            '{4'd2, 1'b0, 6'd1,  32'h8C000000, 16'd0, 1'b0},
            '{4'd3, 1'b0, 6'd1,  32'h8C000000, 16'd0, 1'b0},
            '{4'd4, 1'b0, 6'd1,  32'h8C000000, 16'd1, 1'b0},
            '{4'd0, 1'b0, 6'd2,  32'h1000FFFD, 16'd1, 1'b0},
            '{4'd1, 1'b0, 6'd2,  32'h1000FFFD, 16'd1, 1'b0},
            '{4'd8, 1'b1, 6'd63, 32'h1000FFFD, 16'd2, 1'b0},
            '{4'd0, 1'b0, 6'd0,  32'h0800000A, 16'd2, 1'b0},
            '{4'd1, 1'b0, 6'd0,  32'h0800000A, 16'd2, 1'b0},
            '{4'd9, 1'b0, 6'd10, 32'h0800000A, 16'd3, 1'b0},
            '{4'd0, 1'b0, 6'd11, 32'h00000000, 16'd3, 1'b0},
            '{4'd1, 1'b0, 6'd11, 32'h00000000, 16'd3, 1'b0},
            '{4'd6, 1'b0, 6'd11, 32'h00000000, 16'd3, 1'b0},
            '{4'd7, 1'b0, 6'd11, 32'h00000000, 16'd4, 1'b0},
            '{4'd0, 1'b0, 6'd12, 32'h1000FFFD, 16'd4, 1'b0},
            '{4'd1, 1'b0, 6'd12, 32'h1000FFFD, 16'd4, 1'b0},
            '{4'd8, 1'b0, 6'd12, 32'h1000FFFD, 16'd5, 1'b0},
            '{4'd0, 1'b0, 6'd13, 32'hFC000000, 16'd5, 1'b0},
            '{4'd1, 1'b0, 6'd13, 32'hFC000000, 16'd5, 1'b1},
            '{4'd2, 1'b0, 6'd13, 32'hFC000000, 16'd5, 1'b1},
            '{4'd3, 1'b0, 6'd13, 32'hFC000000, 16'd5, 1'b1},
            '{4'd4, 1'b0, 6'd13, 32'hFC000000, 16'd6, 1'b1}
        };
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h3F};

        // Memory is programmed while reset is held low.
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin
            wr(6'(i), {ops[$urandom_range(0, 4)], 26'($urandom)});
        end
        wr(6'd0,  32'h8C000000);
        wr(6'd1,  32'h1000FFFD);
        wr(6'd63, 32'h0800000A);
        wr(6'd10, 32'h00000000);
        wr(6'd11, 32'h1000FFFD);
        wr(6'd12, 32'hFC000000);
        check("reset_state", 6'd0, 32'd0, 16'd0, 1'b0);
        reset = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].st, vt[i].z, 1'b0, 6'd0, 32'd0);
            check($sformatf("vec%0d", i), vt[i].pc, vt[i].ins,
                  vt[i].cnt, vt[i].ill);
        end
        step(4'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        check("ill_sticky", 6'd14, m_mem[13], 16'd6, 1'b1);

        // Undefined state sets the flag.
        do_reset();
        step(4'd12, 1'b0, 1'b0, 6'd0, 32'd0);
        check("state12", 6'd0, 32'd0, 16'd0, 1'b1);

        // Asynchronous reset in the middle of an instruction.
        do_reset();
        wr(6'd0, 32'h08000009);
        step(4'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        step(4'd1, 1'b0, 1'b0, 6'd0, 32'd0);
        step(4'd9, 1'b0, 1'b0, 6'd0, 32'd0);
        step(4'd4, 1'b0, 1'b0, 6'd0, 32'd0);
        step(4'd4, 1'b0, 1'b0, 6'd0, 32'd0);
        step(4'd4, 1'b0, 1'b0, 6'd0, 32'd0);
        check("pre_rst", 6'd9, 32'h08000009, 16'd4, 1'b0);
        state = 4'd7;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst", 6'd0, 32'd0, 16'd0, 1'b0);
        step(4'd7, 1'b0, 1'b0, 6'd0, 32'd0);
        reset = 1'b1;
        step(4'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        check("mem_kept", 6'd1, 32'h08000009, 16'd0, 1'b0);

        // Same-address write during fetch returns the old word.
        do_reset();
        wr(6'd2, 32'h08000002);
        step(4'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        step(4'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        step(4'd0, 1'b0, 1'b1, 6'd2, 32'h8C00BEEF);
        check("collide_old", 6'd3, 32'h08000002, 16'd0, 1'b0);
        step(4'd1, 1'b0, 1'b0, 6'd0, 32'd0);
        step(4'd9, 1'b0, 1'b0, 6'd0, 32'd0);
        step(4'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        check("collide_new", 6'd3, 32'h8C00BEEF, 16'd1, 1'b0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [3:0] st;
            logic [31:0] d;
            if (i % 150 == 149) do_reset();
            if ($urandom_range(0, 24) == 0) st = 4'($urandom_range(10, 15));
            else st = 4'($urandom_range(0, 9));
            d = {ops[$urandom_range(0, 5)], 26'($urandom)};
            step(st, 1'($urandom), ($urandom_range(0, 3) == 0),
                 6'($urandom), d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
